// File: rtl/sgmii_tx_seq.sv
// sgmii_tx_seq -- SGMII/1000BASE-X transmit ordered-set sequencer.
// Turns the GMII transmit stream (or the autoneg config word) into one
// 8b/10b code-group request per clock for a downstream encoder.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   xmit_cfg   in   1 = send /C/ ordered sets, 0 = idle and data
//   cfg_reg    in   16-bit config word for /C/ sets
//   tx_en      in   GMII transmit enable
//   tx_er      in   GMII transmit error
//   txd        in   GMII transmit octet
//   enc_rdout  in   encoder running disparity after the last group (1 = +)
//   enc_ena    out  encoder enable
//   enc_kin    out  control-code flag
//   enc_datain out  octet to the encoder
//   tx_even    out  1 when the current output slot is even
//   busy       out  frame in progress, /S/ through the last /R/
//
// State table (state_q names the group sent at the NEXT clock edge)
//   IDLE_K | even idle slot, K28.5
//   IDLE_D | odd idle slot, D5.6 or D16.2
//   SOP    | /S/ in place of a data octet
//   DATA   | data octet, or /V/ on tx_er
//   EOP_T  | /T/
//   EOP_R  | first /R/
//   EOP_R2 | second /R/, pads so the next idle lands on an even slot
//   CFG_K  | K28.5 opening a config set, latches cfg_reg
//   CFG_D  | D21.5 or D2.2 (alternating sets)
//   CFG_LO | config word low octet
//   CFG_HI | config word high octet
module sgmii_tx_seq #(
  parameter logic CFG_MODE_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xmit_cfg,
  input  logic [15:0] cfg_reg,
  input  logic        tx_en,
  input  logic        tx_er,
  input  logic [7:0]  txd,
  input  logic        enc_rdout,
  output logic        enc_ena,
  output logic        enc_kin,
  output logic [7:0]  enc_datain,
  output logic        tx_even,
  output logic        busy
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_R   = 8'hF7;
  localparam logic [7:0] K_V   = 8'hFE;

  typedef enum logic [3:0] {
    IDLE_K, IDLE_D, SOP, DATA, EOP_T, EOP_R, EOP_R2,
    CFG_K, CFG_D, CFG_LO, CFG_HI
  } state_t;

  state_t      state_q, state_n, boundary_st;
  logic        tx_en_d, tx_er_d;
  logic [7:0]  txd_d;
  logic        pend_q, pend_n;
  logic        after_r_q, after_r_n;
  logic [15:0] cfg_q, cfg_n;
  logic        cfg_alt_q, cfg_alt_n;
  logic        kin_n, busy_n, rise;
  logic [7:0]  data_n;

  always_comb begin
    state_n     = state_q;
    kin_n       = 1'b1;
    data_n      = K28_5;
    busy_n      = 1'b0;
    pend_n      = 1'b0;
    after_r_n   = after_r_q;
    cfg_n       = cfg_q;
    cfg_alt_n   = cfg_alt_q;
    rise        = tx_en & ~tx_en_d;
    boundary_st = xmit_cfg ? CFG_K : IDLE_K;

    case (state_q)
      IDLE_K: begin
        cfg_alt_n = 1'b0;
        state_n   = IDLE_D;
      end
      IDLE_D: begin
        kin_n  = 1'b0;
        data_n = (enc_rdout && after_r_q) ? D5_6 : D16_2;
        if (xmit_cfg)                   state_n = CFG_K;
        else if (tx_en && (rise || pend_q)) state_n = SOP;
        else                            state_n = IDLE_K;
      end
      SOP: begin
        data_n    = K_S;
        busy_n    = 1'b1;
        after_r_n = 1'b0;
        state_n   = tx_en ? DATA : EOP_T;
      end
      DATA: begin
        kin_n   = tx_er_d;
        data_n  = tx_er_d ? K_V : txd_d;
        busy_n  = 1'b1;
        state_n = tx_en ? DATA : EOP_T;
      end
      EOP_T: begin
        data_n  = K_T;
        busy_n  = 1'b1;
        state_n = EOP_R;
      end
      EOP_R: begin
        data_n    = K_R;
        busy_n    = 1'b1;
        after_r_n = 1'b1;
        // tx_even_q is the parity of the slot after this /R/
        state_n   = tx_even ? boundary_st : EOP_R2;
      end
      EOP_R2: begin
        data_n    = K_R;
        busy_n    = 1'b1;
        after_r_n = 1'b1;
        state_n   = boundary_st;
      end
      CFG_K: begin
        cfg_n     = cfg_reg;
        after_r_n = 1'b0;
        state_n   = CFG_D;
      end
      CFG_D: begin
        kin_n   = 1'b0;
        data_n  = cfg_alt_q ? D2_2 : D21_5;
        state_n = CFG_LO;
      end
      CFG_LO: begin
        kin_n   = 1'b0;
        data_n  = cfg_q[7:0];
        state_n = CFG_HI;
      end
      CFG_HI: begin
        kin_n     = 1'b0;
        data_n    = cfg_q[15:8];
        cfg_alt_n = ~cfg_alt_q;
        state_n   = boundary_st;
      end
      default: state_n = IDLE_K;
    endcase

    // A rise seen at the slot handing over to idle (or on IDLE_K) starts
    // the frame at the following even slot, as long as tx_en holds.
    if (state_n == IDLE_K || state_n == IDLE_D)
      pend_n = tx_en & (pend_q | rise);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CFG_MODE_INIT ? CFG_K : IDLE_K;
      tx_en_d    <= 1'b0;
      tx_er_d    <= 1'b0;
      txd_d      <= 8'h00;
      pend_q     <= 1'b0;
      after_r_q  <= 1'b0;
      cfg_q      <= 16'h0000;
      cfg_alt_q  <= 1'b0;
      enc_ena    <= 1'b0;
      enc_kin    <= 1'b1;
      enc_datain <= K28_5;
      tx_even    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      tx_en_d    <= tx_en;
      tx_er_d    <= tx_er;
      txd_d      <= txd;
      pend_q     <= pend_n;
      after_r_q  <= after_r_n;
      cfg_q      <= cfg_n;
      cfg_alt_q  <= cfg_alt_n;
      enc_ena    <= 1'b1;
      enc_kin    <= kin_n;
      enc_datain <= data_n;
      tx_even    <= ~tx_even;
      busy       <= busy_n;
    end
  end

endmodule
